// File: rtl/mod_mem_stage.sv
// Memory-access stage: request/acknowledge data-memory transaction with pipeline stall and ack timeout.
// Optional one-entry store-to-load bypass buffer enabled by defining MEM_STAGE_BYPASS_EN.
module mod_mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenable,
    input  logic        memwrite,
    input  logic [15:0] aluout,
    input  logic [15:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        stall,
    output logic [15:0] DstData_MEM,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q;
    logic        req_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] load_q;
    logic        err_q;
    logic        is_store_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        bypass_hit;
    logic [15:0] bypass_data;

    assign cnt_d = cnt_q + 8'd1;

`ifdef MEM_STAGE_BYPASS_EN
    logic        buf_vld_q;
    logic [15:0] buf_addr_q;
    logic [15:0] buf_data_q;

    assign bypass_hit  = buf_vld_q && (buf_addr_q == aluout);
    assign bypass_data = buf_data_q;

    // Only acknowledged stores refresh the buffer; a timed-out store never reached memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld_q  <= 1'b0;
            buf_addr_q <= 16'h0000;
            buf_data_q <= 16'h0000;
        end else if (state_q == BUSY && dmem_ack && we_q) begin
            buf_vld_q  <= 1'b1;
            buf_addr_q <= addr_q;
            buf_data_q <= wdata_q;
        end
    end
`else
    assign bypass_hit  = 1'b0;
    assign bypass_data = 16'h0000;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            load_q     <= 16'h0000;
            err_q      <= 1'b0;
            is_store_q <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (memenable) begin
                        is_store_q <= memwrite;
                        if (!memwrite && bypass_hit) begin
                            load_q  <= bypass_data;
                            state_q <= DONE;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= memwrite;
                            addr_q  <= aluout;
                            wdata_q <= store_data;
                            cnt_q   <= 8'd0;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        if (!we_q) begin
                            load_q <= dmem_rdata;
                        end
                        req_q   <= 1'b0;
                        cnt_q   <= 8'd0;
                        state_q <= DONE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        err_q   <= 1'b1;
                        load_q  <= 16'hFFFF;
                        req_q   <= 1'b0;
                        cnt_q   <= 8'd0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                // Same instruction still presents memenable here; leaving unconditionally avoids a retrigger.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: stall must be combinational so the first cycle of an access already freezes the front end.
    assign stall       = (state_q == BUSY) || (state_q == IDLE && memenable);
    assign DstData_MEM = (state_q == DONE && !is_store_q) ? load_q : aluout;

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign mem_err    = err_q;

endmodule

// File: doc/mod_mem_stage.md
# mod_mem_stage

Memory-access stage of the 16-bit five-stage pipeline, directly downstream of the execution stage. Takes the ALU result as an effective address (already halfword-aligned by EX) and the forwarded store data, runs a request/acknowledge transaction against the data memory, and stalls the pipeline until the access completes. Produces the stage result (load data or pass-through ALU result) for the MEM/WB register and for the EX forwarding path (`forward_DstData_MEM`).

## Interface
- `ACK_TIMEOUT`, default 255: maximum number of BUSY cycles without `dmem_ack` before the access is aborted; legal range 1..255.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `memenable`  in  1  current instruction is LW or SW.
- `memwrite`  in  1  1 = SW, 0 = LW; meaningful only when `memenable`=1.
- `aluout`  in  16  effective address from EX (bit 0 always 0).
- `store_data`  in  16  forwarded SW data.
- `dmem_req`  out  1  memory request, registered.
- `dmem_we`  out  1  write enable, registered, valid with `dmem_req`.
- `dmem_addr`  out  16  registered address.
- `dmem_wdata`  out  16  registered write data.
- `dmem_ack`  in  1  memory completion; `dmem_rdata` valid in the same cycle.
- `dmem_rdata`  in  16  read data.
- `stall`  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `DstData_MEM`  out  16  stage result.
- `mem_err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, BUSY, DONE. Reset: state IDLE; `dmem_req`, `dmem_we`, `mem_err` = 0; `dmem_addr`, `dmem_wdata`, load-data register = 16'h0000; bypass buffer invalid.
- IDLE, `memenable`=0: no transaction, `stall`=0, `DstData_MEM` = `aluout`.
- IDLE, `memenable`=1: latch address, data, direction into `dmem_*`; assert `dmem_req` next cycle; go BUSY; `stall`=1 combinationally in this cycle.
- BUSY: `dmem_req`=1, `stall`=1, timeout counter increments each cycle. On `dmem_ack`=1: capture `dmem_rdata` (loads only), drop `dmem_req` next cycle, clear counter, go DONE. If counter reaches `ACK_TIMEOUT` with no ack: set `mem_err`, load-data register = 16'hFFFF, drop `dmem_req`, go DONE.
- DONE: `stall`=0, `DstData_MEM` = load-data register for LW, `aluout` for SW; pipeline advances; unconditionally go IDLE (the still-present `memenable` of the same instruction must not retrigger).
- `mem_err` stays 1 until `rst`.
- `dmem_ack` while IDLE or DONE is ignored.
- Reset in any state: next state IDLE, `dmem_req`=0 after that edge; an in-flight access is abandoned; a later ack is ignored.

## Timing
- Non-memory instruction: 0 added cycles.
- Memory access, ack in first BUSY cycle (cycle 1): IDLE (cycle 0) → BUSY (cycle 1) → DONE (cycle 2); `stall` high cycles 0–1; result valid cycle 2. A k-cycle memory adds k-1 further stall cycles.
- Timeout: `stall` high for 1 + `ACK_TIMEOUT` cycles, then DONE.
- `dmem_addr`/`dmem_wdata`/`dmem_we` stable for the full time `dmem_req`=1.

## Configuration
- `MEM_STAGE_BYPASS_EN` defined: one-entry store buffer (valid, addr, data) is updated when a SW completes with ack, but not on timeout. An LW in IDLE whose address equals a valid buffer entry skips BUSY: it goes directly to DONE with load-data register = buffer data, `dmem_req` is never asserted, and `stall` is high for 1 cycle only. Buffer cleared by `rst`.
- Not defined: no buffer; every LW/SW takes the BUSY path.

## Test plan
- ALU op, `memenable`=0, `aluout`=16'h1234 → `stall`=0, `DstData_MEM`=16'h1234, `dmem_req` never asserted.
- LW addr 16'h0040, ack in first BUSY cycle with rdata 16'hBEEF → `stall` high 2 cycles, `dmem_addr`=16'h0040, `dmem_we`=0; `DstData_MEM`=16'hBEEF in DONE.
- SW addr 16'h0010 data 16'hCAFE, ack after 3 BUSY cycles → `dmem_we`=1, `dmem_wdata`=16'hCAFE held throughout; `stall` high 4 cycles.
- `ACK_TIMEOUT`=4, no ack → `stall` high 5 cycles, then `mem_err`=1, LW result 16'hFFFF; `mem_err` remains 1 across later accesses until `rst`.
- `rst` asserted in the second BUSY cycle, ack arrives the next cycle → `dmem_req`=0 after the reset edge, state IDLE, `stall`=0, ack ignored.
- With `MEM_STAGE_BYPASS_EN`: SW 16'h0020 ← 16'h5A5A, then LW 16'h0020 → no `dmem_req` for the LW, 1 stall cycle, `DstData_MEM`=16'h5A5A; LW 16'h0022 takes the normal BUSY path.
